// File: rtl/wall_column_stepper.sv
// Column row sequencer: fetches one height-ROM word per column and streams one
// classified ceiling/wall/floor pixel per screen row with a Q8.8 texture V.
module wall_column_stepper #(
  parameter int SCREEN_H = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        col_start,
  input  logic [9:0]  col_idx,
  output logic        busy,
  output logic [9:0]  rom_addr,
  input  logic [39:0] rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_y,
  output logic [1:0]  pix_kind,
  output logic [7:0]  pix_tex_v,
  output logic [15:0] pix_inv_dist,
  output logic        pix_last,
  output logic        col_done
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, STREAM} state_t;

  localparam logic [1:0] K_CEIL  = 2'd0;
  localparam logic [1:0] K_WALL  = 2'd1;
  localparam logic [1:0] K_FLOOR = 2'd2;
  localparam logic [8:0] SH      = 9'(SCREEN_H);
  localparam logic [7:0] LAST_Y  = 8'(SCREEN_H - 1);

  state_t      state;
  logic [7:0]  y;
  logic [15:0] acc;
  logic [15:0] scale_q;
  logic [7:0]  wall_top;
  logic [8:0]  wall_bot;

  function automatic logic [1:0] classify(input logic [7:0] yy, input logic [7:0] top,
                                          input logic [8:0] bot);
    if (yy < top)              return K_CEIL;
    else if ({1'b0, yy} < bot) return K_WALL;
    else                       return K_FLOOR;
  endfunction

  // Column setup, evaluated from rom_data while in LATCH
  logic [8:0]  h_in, hc_in;
  logic [7:0]  top_in, skip_in;
  logic [8:0]  bot_in;
  logic [23:0] prod_in;
  logic [15:0] acc_in;
  logic [1:0]  kind0;

  always_comb begin
    h_in    = {1'b0, rom_data[39:32]};
    hc_in   = (h_in > SH) ? SH : h_in;
    top_in  = 8'((SH - hc_in) >> 1);
    bot_in  = {1'b0, top_in} + hc_in;
    skip_in = (h_in > SH) ? 8'((h_in - SH) >> 1) : 8'd0;
    prod_in = {16'd0, skip_in} * {8'd0, rom_data[31:16]};
    acc_in  = prod_in[15:0];
    kind0   = classify(8'd0, top_in, bot_in);
  end

  // Next beat, used only when the current beat is accepted
  logic [7:0]  y_nx;
  logic [15:0] acc_nx;
  logic [1:0]  kind_nx;

  always_comb begin
    y_nx    = y + 8'd1;
    acc_nx  = (pix_kind == K_WALL) ? acc + scale_q : acc;
    kind_nx = classify(y_nx, wall_top, wall_bot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      y            <= '0;
      acc          <= '0;
      scale_q      <= '0;
      wall_top     <= '0;
      wall_bot     <= '0;
      busy         <= 1'b0;
      rom_addr     <= '0;
      pix_valid    <= 1'b0;
      pix_y        <= '0;
      pix_kind     <= K_CEIL;
      pix_tex_v    <= '0;
      pix_inv_dist <= '0;
      pix_last     <= 1'b0;
      col_done     <= 1'b0;
    end else begin
      col_done <= 1'b0;
      case (state)
        IDLE: begin
          if (col_start) begin
            rom_addr <= col_idx;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          scale_q      <= rom_data[31:16];
          wall_top     <= top_in;
          wall_bot     <= bot_in;
          acc          <= acc_in;
          y            <= 8'd0;
          pix_valid    <= 1'b1;
          pix_y        <= 8'd0;
          pix_kind     <= kind0;
          pix_tex_v    <= (kind0 == K_WALL) ? acc_in[15:8] : 8'd0;
          pix_inv_dist <= rom_data[15:0];
          pix_last     <= 1'b0;
          state        <= STREAM;
        end
        STREAM: begin
          if (pix_ready) begin
            acc <= acc_nx;
            if (pix_last) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              col_done  <= 1'b1;
              state     <= IDLE;
            end else begin
              y         <= y_nx;
              pix_y     <= y_nx;
              pix_kind  <= kind_nx;
              pix_tex_v <= (kind_nx == K_WALL) ? acc_nx[15:8] : 8'd0;
              pix_last  <= (y_nx == LAST_Y);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_column_stepper.sv
// Directed + randomized bench for wall_column_stepper against a closed-form
// per-row model of the column (no incremental accumulator).
module tb_wall_column_stepper;
  localparam int SH = 240;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        col_start = 1'b0;
  logic [9:0]  col_idx = '0;
  logic        busy;
  logic [9:0]  rom_addr;
  logic [39:0] rom_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_y;
  logic [1:0]  pix_kind;
  logic [7:0]  pix_tex_v;
  logic [15:0] pix_inv_dist;
  logic        pix_last;
  logic        col_done;

  wall_column_stepper #(.SCREEN_H(SH)) dut (
    .clk(clk), .rst_n(rst_n), .col_start(col_start), .col_idx(col_idx),
    .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_y(pix_y),
    .pix_kind(pix_kind), .pix_tex_v(pix_tex_v), .pix_inv_dist(pix_inv_dist),
    .pix_last(pix_last), .col_done(col_done)
  );

  always #5 clk = ~clk;

  // Height ROM: registered read, one cycle latency
  logic [39:0] rom [1024];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int vectors = 0;
  int miscompares = 0;
  int exp_kind [SH];
  int exp_tex  [SH];
  int exp_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row r of the column, straight from the height/scale definition
  task automatic model(input logic [39:0] w);
    int h, sc, hc, top, bot, skip;
    h = int'(w[39:32]); sc = int'(w[31:16]); exp_inv = int'(w[15:0]);
    hc   = (h > SH) ? SH : h;
    top  = (SH - hc) / 2;
    bot  = top + hc;
    skip = (h > SH) ? (h - SH) / 2 : 0;
    for (int r = 0; r < SH; r++) begin
      if (r < top)      begin exp_kind[r] = 0; exp_tex[r] = 0; end
      else if (r < bot) begin exp_kind[r] = 1; exp_tex[r] = (((skip + r - top) * sc) % 65536) / 256; end
      else              begin exp_kind[r] = 2; exp_tex[r] = 0; end
    end
  endtask

  // Runs one column; returns at the negedge of the col_done cycle so the
  // next call can issue a back-to-back request.
  task automatic run_column(input logic [9:0] idx, input bit rnd);
    int e, b;
    bit done, rdy;
    model(rom[idx]);
    col_start = 1'b1; col_idx = idx; pix_ready = 1'b1;
    @(negedge clk);
    col_start = 1'b0; e = 1; b = 0; done = 0;
    chk("busy_fetch", 32'(busy), 1);
    chk("rom_addr", 32'(rom_addr), 32'(idx));
    while (!done && e < 4000) begin
      if (b == SH) begin
        chk("col_done", 32'(col_done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("valid_end", 32'(pix_valid), 0);
        if (!rnd) chk("col_latency", 32'(e), SH + 3);
        done = 1;
      end else begin
        chk("no_early_done", 32'(col_done), 0);
        chk("valid", 32'(pix_valid), (e >= 3) ? 1 : 0);
        if (pix_valid) begin
          chk("pix_y", 32'(pix_y), 32'(b));
          chk("pix_kind", 32'(pix_kind), 32'(exp_kind[b]));
          chk("pix_tex_v", 32'(pix_tex_v), 32'(exp_tex[b]));
          chk("pix_inv_dist", 32'(pix_inv_dist), 32'(exp_inv));
          chk("pix_last", 32'(pix_last), (b == SH - 1) ? 1 : 0);
        end
        if (e == 22) chk("rom_addr_hold", 32'(rom_addr), 32'(idx));
        if (e == 20) begin col_start = 1'b1; col_idx = idx ^ 10'h3ff; end
        else col_start = 1'b0;
        rdy = rnd ? (($urandom % 4) != 0) : 1'b1;
        pix_ready = rdy;
        if (pix_valid && rdy) b++;
        @(negedge clk); e++;
      end
    end
    if (!done) chk("timeout", 0, 1);
    pix_ready = 1'b1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) rom[i] = {$urandom, $urandom_range(0, 255)};
    rom[5] = {8'd100, 16'h0280, 16'h0123};
    rom[6] = {8'd0,   16'h1234, 16'h0abc};
    rom[7] = {8'd255, 16'h0100, 16'h7777};
    rom[8] = {8'd101, 16'h0100, 16'h0042};
    rom[9] = {8'd150, 16'h0000, 16'h0055};

    // Reset state
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_y", 32'(pix_y), 0);
    chk("rst_kind", 32'(pix_kind), 0);
    chk("rst_tex", 32'(pix_tex_v), 0);
    chk("rst_inv", 32'(pix_inv_dist), 0);
    chk("rst_last", 32'(pix_last), 0);
    chk("rst_done", 32'(col_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_column(10'd5, 1'b0);   // h=100 reference column
    repeat (2) @(negedge clk);
    run_column(10'd6, 1'b0);   // h=0
    run_column(10'd7, 1'b0);   // h=255, back-to-back
    run_column(10'd9, 1'b0);   // scale=0, back-to-back
    repeat (3) @(negedge clk);
    run_column(10'd8, 1'b1);   // h=101 with backpressure
    @(negedge clk);
    run_column(10'd8, 1'b0);

    // Reset mid-column at y = 50
    col_start = 1'b1; col_idx = 10'd5;
    @(negedge clk);
    col_start = 1'b0; guard = 0;
    while (!(pix_valid && pix_y == 8'd50) && guard < 1000) begin
      @(negedge clk); guard++;
    end
    chk("reach_y50", (guard < 1000) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(pix_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_y", 32'(pix_y), 0);
    chk("mid_rst_kind", 32'(pix_kind), 0);
    chk("mid_rst_inv", 32'(pix_inv_dist), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    @(negedge clk);
    chk("mid_rst_no_done", 32'(col_done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", 32'(col_done), 0);
    run_column(10'd5, 1'b0);

    // Random columns
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_column(10'($urandom_range(10, 1023)), k[0]);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
